fp_latency_tracker: RTL
=======================

Name: fp_latency_tracker

Overview:
- Generic issue/completion controller wrapped around any fixed-latency, clock-enabled floating-point megafunction core (sin, cos, div, sqrt, ...).
- Generates the core's clock enable and tracks every in-flight operation with a valid/tag shift pipeline.
- Returns a registered result with done pulse and tag.
- Supports fully pipelined issue (one op per cycle) or single-op mode with busy/drop reporting.

Parameters:
- LATENCY, 37, core latency in enabled clock cycles; legal range 1..64.
- DATA_W, 32, operand/result width.
- TAG_W, 4, user tag width carried alongside each op.
- PIPELINED, 1, 1 = accept a new op every cycle; 0 = accept only when nothing is in flight.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request to issue an op this cycle.
- data  in  DATA_W  operand, valid with start.
- tag  in  TAG_W  user tag, valid with start.
- flush  in  1  synchronous abort of all in-flight ops.
- core_clk_en  out  1  clock enable to the core.
- core_data  out  DATA_W  operand to the core; combinational pass-through of data.
- core_result  in  DATA_W  core output.
- result  out  DATA_W  registered result.
- result_tag  out  TAG_W  tag of the op whose result is presented.
- done  out  1  one-cycle pulse, result/result_tag valid.
- busy  out  1  at least one op in flight.
- dropped  out  1  one-cycle pulse, start was refused.
- inflight  out  7  count of ops in flight, 0..LATENCY.

Behaviour:
- Reset (async, reset_n=0):
  - valid pipe v[1..LATENCY] cleared; tag pipe cleared.
  - result=0, result_tag=0, done=0, dropped=0, inflight=0, busy=0.
- accept = start & ~flush & (PIPELINED | ~busy).
- dropped (registered) = start & ~accept & ~flush of the previous cycle.
- core_clk_en = accept | busy. This is combinational; busy = |v.
- Advance: on each edge with core_clk_en=1:
  - v[1] <= accept, v[k] <= v[k-1]; the tag pipe shifts identically.
  - With core_clk_en=0 nothing shifts.
- Result capture: when v[LATENCY]=1 at an edge:
  - result <= core_result; result_tag <= tag pipe[LATENCY]; done <= 1.
  - Otherwise done <= 0, and result and result_tag hold.
- Latency: start sampled at edge of cycle 0 -> done high in cycle LATENCY+1, exactly one cycle per op.
- Back-to-back (PIPELINED=1):
  - N consecutive starts give N consecutive done pulses, in order, tags preserved.
  - Gaps between starts are preserved in the done stream.
- PIPELINED=0:
  - A start while busy=1 is ignored and dropped pulses.
  - A start in the same cycle as the final done is accepted (busy already 0 then).
- inflight: +1 on accept, -1 when v[LATENCY] shifts out; both in the same cycle leaves it unchanged.
- flush:
  - Clears v and inflight at the next edge; any in-flight results are never reported.
  - A done already registered still pulses.
  - flush overrides a simultaneous start, and no dropped pulse is raised for it.
- LATENCY=1: v is a single bit; done comes 2 cycles after start; full-rate issue is still allowed.
- reset_n asserted mid-operation: everything clears immediately, and no done is emitted for ops issued before reset.

Test Plan:
- LATENCY=37, PIPELINED=1, behavioural core = 37-stage enabled delay of data+1: single start data=0x3F800000 tag=5 -> done only in cycle 38, result=0x3F800001, result_tag=5, busy high cycles 1..37, inflight peaks at 1.
- PIPELINED=1: 8 consecutive starts, data=1..8, tag=0..7 -> 8 consecutive done pulses in cycles 38..45, results 2..9, tags 0..7, inflight peaks at 8, dropped never asserted.
- PIPELINED=0: start at cycle 0, start again at cycle 10 -> dropped pulses in cycle 11, one done only; a new start in cycle 38 is accepted and done follows in cycle 76.
- flush asserted in cycle 20 with 3 ops in flight, plus a simultaneous start -> no done ever for those ops, inflight=0 and busy=0 from cycle 21, core_clk_en low afterwards.
- reset_n pulled low in cycle 15 with 2 ops in flight -> all outputs 0 immediately, no done after release, and a new start after release completes normally at +38.
- LATENCY=1 with continuous start for 4 cycles -> done high for 4 consecutive cycles starting 2 cycles after the first start, results in order.

Source files
------------

// File: rtl/fp_latency_tracker.sv
// Issue/completion controller for a fixed-latency, clock-enabled FP core.
// Tracks in-flight ops with a valid/tag shift pipe and registers the result.
module fp_latency_tracker #(
    parameter int LATENCY   = 37,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter bit PIPELINED = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [TAG_W-1:0]  tag,
    input  logic              flush,
    output logic              core_clk_en,
    output logic [DATA_W-1:0] core_data,
    input  logic [DATA_W-1:0] core_result,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  result_tag,
    output logic              done,
    output logic              busy,
    output logic              dropped,
    output logic [6:0]        inflight
);

    logic [LATENCY-1:0] r_v;
    logic [TAG_W-1:0]   r_tag [LATENCY];
    logic [DATA_W-1:0]  r_result;
    logic [TAG_W-1:0]   r_result_tag;
    logic               r_done;
    logic               r_dropped;
    logic [6:0]         r_inflight;

    logic w_busy;
    logic w_accept;
    logic w_en;
    logic w_last;
    logic w_capture;

    assign w_busy    = |r_v;
    assign w_accept  = start & ~flush & (PIPELINED | ~w_busy);
    assign w_en      = w_accept | w_busy;
    assign w_last    = r_v[LATENCY-1];
    // An op leaving the pipe in a flush cycle is aborted, not reported
    assign w_capture = w_last & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else if (w_en) begin
            r_v    <= r_v << 1;
            r_v[0] <= w_accept;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LATENCY; k++) r_tag[k] <= '0;
        end else if (w_en) begin
            for (int k = LATENCY - 1; k > 0; k--) r_tag[k] <= r_tag[k-1];
            r_tag[0] <= tag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result     <= '0;
            r_result_tag <= '0;
            r_done       <= 1'b0;
            r_dropped    <= 1'b0;
            r_inflight   <= '0;
        end else begin
            r_done    <= w_capture;
            r_dropped <= start & ~w_accept & ~flush;
            if (w_capture) begin
                r_result     <= core_result;
                r_result_tag <= r_tag[LATENCY-1];
            end
            if (flush) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= r_inflight + {6'd0, w_accept} - {6'd0, w_last};
            end
        end
    end

    assign core_clk_en = w_en;
    assign core_data   = data;
    assign result      = r_result;
    assign result_tag  = r_result_tag;
    assign done        = r_done;
    assign busy        = w_busy;
    assign dropped     = r_dropped;
    assign inflight    = r_inflight;

endmodule
